// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: widths, bubble encoding, opcodes and the fetch state encoding.
package cpu_pkg;

  localparam int unsigned PC_WIDTH     = 8;
  localparam int unsigned INSTR_WIDTH  = 16;
  localparam int unsigned OPCODE_WIDTH = 4;

  localparam logic [PC_WIDTH-1:0]    RESET_PC  = 8'h00;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'hF000;

  // Opcode map shared with decode; 4'hF is reserved for the fetch bubble.
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD  = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_ST  = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_t;

  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Single-outstanding req/gnt/rvalid instruction-memory port.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INSTR_WIDTH-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} parking register for a fetch that returns while decode is stalled.
module fetch_hold_buf #(
  parameter int unsigned INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter int unsigned PC_WIDTH    = cpu_pkg::PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   drain,
  input  logic                   clear,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]    pc_in,
  output logic                   valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc
);

  // Clear (redirect) wins over a same-cycle load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem port, and fills the IF/ID register
// with stall, flush and branch-redirect handling.
module fetch_stage #(
  parameter int unsigned                 PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int unsigned                 INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]         RESET_PC    = cpu_pkg::RESET_PC,
  parameter logic [INSTR_WIDTH-1:0]      NOP_INSTR   = cpu_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  fetch_stage_if.master          imem,
  output logic                   if_id_valid,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc
);

  import cpu_pkg::fetch_state_t;
  import cpu_pkg::ST_IDLE;
  import cpu_pkg::ST_REQ;
  import cpu_pkg::ST_WAIT;
  import cpu_pkg::ST_HOLD;
  import cpu_pkg::ST_DROP;

  fetch_state_t          state, state_n;
  logic [PC_WIDTH-1:0]   pc, pc_n;
  logic [PC_WIDTH-1:0]   req_pc, req_pc_n;
  logic                  load_fetch;
  logic                  hold_load;
  logic                  hold_drain;
  logic                  hold_clear;
  logic                  hold_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic [PC_WIDTH-1:0]   hold_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      req_pc <= req_pc_n;
    end
  end

  // Next state, next PC and the IF/ID / hold-buffer load strobes.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_pc_n   = req_pc;
    load_fetch = 1'b0;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    hold_clear = redirect_valid;

    unique case (state)
      ST_IDLE: begin
        state_n = ST_REQ;
        if (redirect_valid) pc_n = redirect_pc;
      end
      ST_REQ: begin
        if (imem.gnt) begin
          req_pc_n = pc;
          if (redirect_valid) begin
            pc_n    = redirect_pc;
            state_n = ST_DROP;
          end else begin
            pc_n    = pc + PC_WIDTH'(1);
            state_n = ST_WAIT;
          end
        end else if (redirect_valid) begin
          pc_n = redirect_pc;
        end
      end
      ST_WAIT: begin
        if (imem.rvalid) begin
          state_n = ST_REQ;
          if (redirect_valid) begin
            pc_n = redirect_pc;
          end else if (!stall) begin
            load_fetch = 1'b1;
          end else begin
            hold_load = 1'b1;
            state_n   = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = ST_REQ;
        end else if (!stall) begin
          hold_drain = 1'b1;
          state_n    = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_valid) pc_n = redirect_pc;
        if (imem.rvalid) state_n = ST_REQ;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Request/address are registered from next-state so no imem input reaches imem.req combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem.req  <= 1'b0;
      imem.addr <= RESET_PC;
    end else begin
      imem.req  <= (state_n == ST_REQ);
      imem.addr <= pc_n;
    end
  end

  fetch_hold_buf #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .drain    (hold_drain),
    .clear    (hold_clear),
    .instr_in (imem.rdata),
    .pc_in    (req_pc),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );

  // IF/ID: bubble on redirect/flush, freeze on stall, otherwise take new data or go empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (redirect_valid || flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (!stall) begin
      if (load_fetch) begin
        if_id_valid <= 1'b1;
        if_id_instr <= imem.rdata;
        if_id_pc    <= req_pc;
      end else if (hold_drain) begin
        if_id_valid <= hold_valid;
        if_id_instr <= hold_instr;
        if_id_pc    <= hold_pc;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= '0;
      end
    end
  end

  rvalid_in_window: assert property (@(posedge clk) disable iff (!reset)
    imem.rvalid |-> (state == ST_WAIT || state == ST_DROP));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/hold, redirect-drop, flush, PC wrap, async reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [7:0]  if_id_pc;

  logic [15:0] mem [256];
  int          pend;
  logic [15:0] pend_data;
  int          lat;
  logic        gnt_en;

  int checks;
  int errors;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] instr,
                            input logic [7:0] pc);
    check({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check({tag, ".instr"}, 32'(if_id_instr), 32'(instr));
    check({tag, ".pc"},    32'(if_id_pc),    32'(pc));
  endtask

  task automatic check_req(input string tag, input logic req, input logic [7:0] addr);
    check({tag, ".req"},  32'(imem_bus.req),  32'(req));
    check({tag, ".addr"}, 32'(imem_bus.addr), 32'(addr));
  endtask

  // Memory model: grants while enabled, returns mem[addr] 'lat' cycles after the grant.
  initial begin
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 16'h0000;
    pend            = 0;
    pend_data       = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      imem_bus.rvalid = 1'b0;
      imem_bus.gnt    = 1'b0;
      if (!reset) begin
        pend = 0;
      end else begin
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            imem_bus.rvalid = 1'b1;
            imem_bus.rdata  = pend_data;
          end
        end
        if (imem_bus.req && gnt_en) begin
          imem_bus.gnt = 1'b1;
          pend         = lat;
          pend_data    = mem[imem_bus.addr];
        end
      end
    end
  end

  initial begin
    checks         = 0;
    errors         = 0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    gnt_en         = 1'b1;
    lat            = 1;
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);
    mem[4] = 16'h2A55;
    reset = 1'b1;
    #2 reset = 1'b0;

    repeat (2) @(negedge clk);
    check_req("rst", 1'b0, 8'h00);
    check_ifid("rst", 1'b0, 16'hF000, 8'h00);
    reset = 1'b1;

    @(negedge clk);
    check_req("first_req", 1'b1, 8'h00);
    @(negedge clk);
    check("first_wait.valid", 32'(if_id_valid), 32'(0));

    // Streaming: one instruction every two cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_ifid($sformatf("stream%0d", i), 1'b1, 16'(16'h1000 + i), 8'(i));
      if (i < 3) begin
        @(negedge clk);
        check($sformatf("stream_gap%0d", i), 32'(if_id_valid), 32'(0));
      end
    end

    // Stall held for three cycles while the fetch of pc 4 returns
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_ifid($sformatf("stall_hold%0d", k), 1'b1, 16'h1003, 8'h03);
    end
    check("hold.req", 32'(imem_bus.req), 32'(0));
    stall = 1'b0;
    lat   = 3;
    @(negedge clk);
    check_ifid("unstall", 1'b1, 16'h2A55, 8'h04);
    check_req("unstall", 1'b1, 8'h05);

    // Redirect while waiting; late data must be dropped
    @(negedge clk);
    check("redir_pre.valid", 32'(if_id_valid), 32'(0));
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check_req("drop0", 1'b0, 8'h40);
    check("drop0.valid", 32'(if_id_valid), 32'(0));
    @(negedge clk);
    lat = 1;
    check("drop1.valid", 32'(if_id_valid), 32'(0));
    @(negedge clk);
    check_req("redir_req", 1'b1, 8'h40);
    check("redir_req.valid", 32'(if_id_valid), 32'(0));
    repeat (2) @(negedge clk);
    check_ifid("redir_fetch", 1'b1, 16'h1040, 8'h40);

    // Flush beats stall
    flush = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    check_ifid("flush_stall", 1'b0, 16'hF000, 8'h00);
    @(negedge clk);
    check_ifid("after_flush", 1'b1, 16'h1041, 8'h41);

    // Redirect coincident with grant, then PC wrap at 8'hFF
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    check_req("wrap_req", 1'b1, 8'hFF);
    check("wrap_req.valid", 32'(if_id_valid), 32'(0));
    @(negedge clk);
    gnt_en = 1'b0;
    @(negedge clk);
    check_ifid("wrap_data", 1'b1, 16'h10FF, 8'hFF);
    check_req("wrap_next", 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_req($sformatf("no_gnt%0d", k), 1'b1, 8'h00);
      if (k == 2) gnt_en = 1'b1;
    end
    repeat (2) @(negedge clk);
    check_ifid("wrap_fetch", 1'b1, 16'h1000, 8'h00);

    // Asynchronous reset in the middle of a WAIT
    @(negedge clk);
    check("pre_rst.req", 32'(imem_bus.req), 32'(0));
    reset = 1'b0;
    #1;
    check_req("async_rst", 1'b0, 8'h00);
    check_ifid("async_rst", 1'b0, 16'hF000, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_req("post_rst", 1'b1, 8'h00);
    check("post_rst.valid", 32'(if_id_valid), 32'(0));
    repeat (2) @(negedge clk);
    check_ifid("post_rst_fetch", 1'b1, 16'h1000, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
